// File: rtl/branch_resolve_queue_if.sv
// Handshake and result bundle between fetch/execute and the branch resolve queue.
// The slave side is the queue itself.
interface branch_resolve_queue_if #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  push_valid_i;
    logic                  push_ready_o;
    logic                  push_pred_taken_i;
    logic [ADDR_WIDTH-1:0] push_alt_pc_i;
    logic                  resolve_valid_i;
    logic                  resolve_taken_i;
    logic                  bpu_cond_jump_o;
    logic                  bpu_shouldnt_jump_o;
    logic                  redirect_valid_o;
    logic [ADDR_WIDTH-1:0] redirect_pc_o;
    logic [CW-1:0]         count_o;
    logic                  underflow_err_o;

    modport slave (
        input  push_valid_i, push_pred_taken_i, push_alt_pc_i,
        input  resolve_valid_i, resolve_taken_i,
        output push_ready_o, bpu_cond_jump_o, bpu_shouldnt_jump_o,
        output redirect_valid_o, redirect_pc_o, count_o, underflow_err_o
    );

    modport master (
        output push_valid_i, push_pred_taken_i, push_alt_pc_i,
        output resolve_valid_i, resolve_taken_i,
        input  push_ready_o, bpu_cond_jump_o, bpu_shouldnt_jump_o,
        input  redirect_valid_o, redirect_pc_o, count_o, underflow_err_o
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted conditional branches; resolves the head against the
// actual outcome, pulses the L1 predictor update and redirects fetch on a mispredict.
module branch_resolve_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    branch_resolve_queue_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                state, state_nxt;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  mem_pred [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_alt  [DEPTH];

    logic push_ready, push_acc, pop_acc, under_hit, mispredict;

    always_comb begin
        state_nxt  = state;
        push_ready = (state == RUN) && (count != CW'(DEPTH));
        push_acc   = bus.push_valid_i && push_ready;
        pop_acc    = bus.resolve_valid_i && (state == RUN) && (count != '0);
        under_hit  = bus.resolve_valid_i && (state == RUN) && (count == '0);
        mispredict = pop_acc && (mem_pred[rd_ptr] ^ bus.resolve_taken_i);
        case (state)
            RUN:     if (mispredict) state_nxt = FLUSH;
            FLUSH:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) state <= RUN;
        else        state <= state_nxt;
    end

    // A mispredict squashes every younger entry, including a same-cycle push.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (mispredict) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_acc) - CW'(pop_acc);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_acc && !mispredict) begin
            mem_pred[wr_ptr] <= bus.push_pred_taken_i;
            mem_alt[wr_ptr]  <= bus.push_alt_pc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            bus.bpu_cond_jump_o     <= 1'b0;
            bus.bpu_shouldnt_jump_o <= 1'b0;
            bus.redirect_valid_o    <= 1'b0;
            bus.redirect_pc_o       <= '0;
            bus.underflow_err_o     <= 1'b0;
        end else begin
            bus.bpu_cond_jump_o     <= pop_acc;
            bus.bpu_shouldnt_jump_o <= mispredict;
            bus.redirect_valid_o    <= mispredict;
            if (mispredict) bus.redirect_pc_o <= mem_alt[rd_ptr];
            if (under_hit)  bus.underflow_err_o <= 1'b1;
        end
    end

    assign bus.push_ready_o = push_ready;
    assign bus.count_o      = count;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue against a queue-based model.
module tb_branch_resolve_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 16;

    typedef struct packed {
        logic          pred;
        logic [AW-1:0] alt;
    } ent_t;

    logic clk_i = 1'b0;
    logic srst_i;
    always #5 clk_i = ~clk_i;

    branch_resolve_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) b ();

    branch_resolve_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .bus    (b.slave)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model state
    ent_t          q[$];
    bit            m_flush;
    bit            m_err, m_cond, m_sj, m_rv;
    logic [AW-1:0] m_rpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input logic pv, input logic pt, input logic [AW-1:0] pa,
                       input logic rv, input logic rt, input logic rst);
        bit   ready;
        bit   mis;
        ent_t h;
        b.push_valid_i      = pv;
        b.push_pred_taken_i = pt;
        b.push_alt_pc_i     = pa;
        b.resolve_valid_i   = rv;
        b.resolve_taken_i   = rt;
        srst_i              = rst;
        ready = !m_flush && (q.size() < DEPTH);
        #1;
        if (!rst) chk("push_ready", 32'(b.push_ready_o), 32'(ready));
        @(posedge clk_i);
        if (rst) begin
            q.delete();
            m_flush = 0; m_err = 0; m_cond = 0; m_sj = 0; m_rv = 0; m_rpc = '0;
        end else begin
            mis = 0; m_cond = 0; m_sj = 0; m_rv = 0;
            if (rv && !m_flush) begin
                if (q.size() == 0) m_err = 1;
                else begin
                    h = q.pop_front();
                    m_cond = 1;
                    if (h.pred != rt) begin
                        mis = 1; m_sj = 1; m_rv = 1; m_rpc = h.alt;
                        q.delete();
                    end
                end
            end
            if (pv && ready && !mis) q.push_back('{pred: pt, alt: pa});
            m_flush = mis;
        end
        #1;
        chk("count",     32'(b.count_o),             32'(q.size()));
        chk("cond_jump", 32'(b.bpu_cond_jump_o),     32'(m_cond));
        chk("shouldnt",  32'(b.bpu_shouldnt_jump_o), 32'(m_sj));
        chk("redir_vld", 32'(b.redirect_valid_o),    32'(m_rv));
        chk("redir_pc",  32'(b.redirect_pc_o),       32'(m_rpc));
        chk("underflow", 32'(b.underflow_err_o),     32'(m_err));
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        b.push_valid_i = 0; b.push_pred_taken_i = 0; b.push_alt_pc_i = '0;
        b.resolve_valid_i = 0; b.resolve_taken_i = 0; srst_i = 1;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("rst_ready", 32'(b.push_ready_o), 32'd1);

        // Fill to DEPTH, then a dropped push
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, AW'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
        chk("full_count", 32'(b.count_o), 32'd4);
        chk("full_ready", 32'(b.push_ready_o), 32'd0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Correct prediction
        cyc(1'b1, 1'b1, 16'h0104, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("ok_cond", 32'(b.bpu_cond_jump_o), 32'd1);

        // Mispredict with flush, then recovery
        cyc(1'b1, 1'b0, 16'h2000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'h3000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'h3004, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("mis_pc", 32'(b.redirect_pc_o), 32'h2000);
        chk("flush_ready", 32'(b.push_ready_o), 32'd0);
        cyc(1'b1, 1'b0, 16'h4444, 1'b1, 1'b0, 1'b0);
        idle();

        // Mispredict with simultaneous push
        cyc(1'b1, 1'b1, 16'h5000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h5004, 1'b1, 1'b0, 1'b0);
        chk("mis_push_count", 32'(b.count_o), 32'd0);
        idle();

        // Full queue, correct resolve + refused push, then wrap pairs
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'(i & 1), AW'(16'h6000 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h6FFF, 1'b1, 1'b0, 1'b0);
        chk("full_pop_count", 32'(b.count_o), 32'd3);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, AW'(16'h7000 + i), 1'b1, q[0].pred, 1'b0);

        // Underflow, then reset with entries queued
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("err_sticky", 32'(b.underflow_err_o), 32'd1);
        cyc(1'b1, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h8004, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h8008, 1'b1, 1'b1, 1'b1);
        chk("rst_err", 32'(b.underflow_err_o), 32'd0);

        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 99) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
